switch_bank_ctrl: RTL and testbench

Parametrised multi-channel successor to the single-switch debounce/LED-toggle path. Per channel:
- synchronises and debounces a raw push-button;
- emits one-cycle press, release and long-press pulses;
- drives an LED in toggle or momentary mode, selectable at run time.

Sits between Go Board switch pins and user logic/LEDs; replaces per-switch debounce and toggle instances in top-level designs.

---
 rtl/switch_pkg.sv | 22 ++
 rtl/switch_channel.sv | 98 +++++++++
 rtl/switch_bank_ctrl.sv | 41 ++++
 tb/tb_switch_bank_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared definitions for the switch bank: LED mode encodings, per-channel
// hold-FSM states and the bundle of per-channel outputs.
package switch_pkg;

  localparam logic MODE_TOGGLE    = 1'b0;
  localparam logic MODE_MOMENTARY = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } sw_state_e;

  typedef struct packed {
    logic deb;
    logic press;
    logic release_p;
    logic long_press;
    logic led;
  } ch_out_t;

endpackage

// File: rtl/switch_channel.sv
// One switch channel: 2-flop sync, restart-on-glitch debounce, edge pulses,
// short/long hold FSM and toggle/momentary LED driver.
module switch_channel
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT   = 250000,
  parameter int LONG_PRESS_LIMIT = 12500000
) (
  input  logic    i_Clk,
  input  logic    i_Reset,
  input  logic    i_Switch,
  input  logic    i_Mode,
  output ch_out_t o_Ch
);

  localparam int DW = (DEBOUNCE_LIMIT > 0) ? $clog2(DEBOUNCE_LIMIT + 1) : 1;
  localparam int HW = (LONG_PRESS_LIMIT > 1) ? $clog2(LONG_PRESS_LIMIT) : 1;

  logic [1:0]    sync_q;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          deb_q, deb_d, deb_dly_q;
  logic          press_q, release_q, long_q, long_d;
  logic          led_q, led_d;
  logic [HW-1:0] hold_q, hold_d;
  sw_state_e     state_q, state_d;
  logic          rise, fall;

  // Any cycle where sync agrees with the accepted level restarts the window.
  always_comb begin
    db_cnt_d = '0;
    deb_d    = deb_q;
    if (sync_q[1] != deb_q) begin
      if (db_cnt_q == DW'(DEBOUNCE_LIMIT - 1)) deb_d = sync_q[1];
      else                                     db_cnt_d = db_cnt_q + DW'(1);
    end
  end

  assign rise = deb_q & ~deb_dly_q;
  assign fall = ~deb_q & deb_dly_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    long_d  = 1'b0;
    unique case (state_q)
      IDLE: if (rise) begin
        state_d = PRESSED;
        hold_d  = '0;
      end
      PRESSED: begin
        if (fall) state_d = IDLE;
        else if (hold_q == HW'(LONG_PRESS_LIMIT - 1)) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end else hold_d = hold_q + HW'(1);
      end
      LONG_HELD: if (fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Only a short release toggles; a long release is left for other uses.
  always_comb begin
    led_d = led_q;
    if (i_Mode == MODE_MOMENTARY)           led_d = deb_q;
    else if (fall && (state_q == PRESSED))  led_d = ~led_q;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sync_q    <= '0;
      db_cnt_q  <= '0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      led_q     <= 1'b0;
      hold_q    <= '0;
      state_q   <= IDLE;
    end else begin
      sync_q    <= {sync_q[0], i_Switch};
      db_cnt_q  <= db_cnt_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      press_q   <= rise;
      release_q <= fall;
      long_q    <= long_d;
      led_q     <= led_d;
      hold_q    <= hold_d;
      state_q   <= state_d;
    end
  end

  assign o_Ch = '{deb: deb_q, press: press_q, release_p: release_q,
                  long_press: long_q, led: led_q};

endmodule

// File: rtl/switch_bank_ctrl.sv
// Bank of NUM_CH independent debounced switch channels with press/release/
// long-press pulses and per-channel LED mode.
module switch_bank_ctrl
  import switch_pkg::*;
#(
  parameter int NUM_CH           = 4,
  parameter int DEBOUNCE_LIMIT   = 250000,
  parameter int LONG_PRESS_LIMIT = 12500000
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic [NUM_CH-1:0] i_Switch,
  input  logic [NUM_CH-1:0] i_Mode,
  output logic [NUM_CH-1:0] o_Debounced,
  output logic [NUM_CH-1:0] o_Press,
  output logic [NUM_CH-1:0] o_Release,
  output logic [NUM_CH-1:0] o_Long_Press,
  output logic [NUM_CH-1:0] o_LED
);

  ch_out_t [NUM_CH-1:0] ch_out;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    switch_channel #(
      .DEBOUNCE_LIMIT  (DEBOUNCE_LIMIT),
      .LONG_PRESS_LIMIT(LONG_PRESS_LIMIT)
    ) u_ch (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .i_Switch(i_Switch[g]),
      .i_Mode  (i_Mode[g]),
      .o_Ch    (ch_out[g])
    );
    assign o_Debounced[g]  = ch_out[g].deb;
    assign o_Press[g]      = ch_out[g].press;
    assign o_Release[g]    = ch_out[g].release_p;
    assign o_Long_Press[g] = ch_out[g].long_press;
    assign o_LED[g]        = ch_out[g].led;
  end

endmodule

// File: tb/tb_switch_bank_ctrl.sv
// Scoreboard bench for switch_bank_ctrl: stimulus pushes expected pulse events
// (cycle, channel, kind, LED level); a negedge monitor pops and compares them.
module tb_switch_bank_ctrl;
  localparam int NCH = 4;
  localparam int DBL = 4;
  localparam int LPL = 20;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] sw, mode;
  logic [NCH-1:0] deb, press, rel, lng, led;

  switch_bank_ctrl #(.NUM_CH(NCH), .DEBOUNCE_LIMIT(DBL), .LONG_PRESS_LIMIT(LPL)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Switch(sw), .i_Mode(mode),
    .o_Debounced(deb), .o_Press(press), .o_Release(rel),
    .o_Long_Press(lng), .o_LED(led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = press, 1 = release, 2 = long press
  typedef struct {int cyc; int ch; int kind; logic led;} ev_t;
  ev_t exp_q[$];
  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      logic [2:0] p;
      ev_t e;
      p = {lng[c], rel[c], press[c]};
      for (int k = 0; k < 3; k++) begin
        if (p[k]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse ch%0d kind %0d cycle %0d, required no pulse", c, k, cyc);
          end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.ch != c || e.kind != k || e.led !== led[c]) begin
              errors++;
              $display("FAIL pulse got ch%0d kind %0d cycle %0d led %b, required ch%0d kind %0d cycle %0d led %b",
                       c, k, cyc, led[c], e.ch, e.kind, e.cyc, e.led);
            end
          end
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int c, input int ch, input int k, input logic l);
    ev_t e;
    e.cyc = c; e.ch = ch; e.kind = k; e.led = l;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", nm, got, req);
    end
  endtask

  function automatic logic [31:0] all_out();
    return 32'({deb, press, rel, lng, led});
  endfunction

  initial begin
    int e0, b, l0, m, r, s;
    logic [0:5] pat;
    pat  = 6'b101101;
    rst  = 1'b1;
    sw   = '1;
    mode = '0;

    // reset held 3 cycles with all switches pressed
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("reset_outputs", all_out(), 32'h0);
    end
    rst = 1'b0; sw = '0;
    tick(1);
    chk("post_reset_outputs", all_out(), 32'h0);
    tick(5);

    // clean press/release on ch0, toggle mode
    e0 = cyc; sw[0] = 1'b1;
    push(e0 + 7, 0, 0, 1'b0);
    tick(5);  chk("ch0_deb_early", 32'(deb[0]), 32'h0);
    tick(1);  chk("ch0_deb_rise",  32'(deb[0]), 32'h1);
    tick(4);
    e0 = cyc; sw[0] = 1'b0;
    push(e0 + 7, 0, 1, 1'b1);
    tick(15);

    // bouncing press on ch1
    b = cyc;
    for (int i = 0; i < 6; i++) begin
      sw[1] = pat[i];
      if (i < 5) tick(1);
    end
    push(b + 12, 1, 0, 1'b0);
    tick(10); chk("ch1_deb_after_bounce", 32'(deb[1]), 32'h1);
    b = cyc; sw[1] = 1'b0;
    push(b + 7, 1, 1, 1'b1);
    tick(15);

    // long press on ch2: long release must not toggle LED
    l0 = cyc; sw[2] = 1'b1;
    push(l0 + 7, 2, 0, 1'b0);
    push(l0 + 27, 2, 2, 1'b0);
    tick(30);
    sw[2] = 1'b0;
    push(l0 + 37, 2, 1, 1'b0);
    tick(15);
    chk("ch2_led_after_long", 32'(led[2]), 32'h0);

    // momentary mode on ch3
    mode[3] = 1'b1;
    tick(2);
    m = cyc; sw[3] = 1'b1;
    push(m + 7, 3, 0, 1'b1);
    tick(6); chk("ch3_mom_lag", 32'({deb[3], led[3]}), 32'h2);
    tick(1); chk("ch3_mom_follow", 32'({deb[3], led[3]}), 32'h3);
    tick(3);
    m = cyc; sw[3] = 1'b0;
    push(m + 7, 3, 1, 1'b0);
    tick(15);
    m = cyc; sw[3] = 1'b1;
    push(m + 7, 3, 0, 1'b1);
    tick(9);
    mode[3] = 1'b0;
    tick(3); chk("ch3_mode_switch_hold", 32'(led[3]), 32'h1);
    m = cyc; sw[3] = 1'b0;
    push(m + 7, 3, 1, 1'b0);
    tick(15);

    // reset in PRESSED at hold count 10
    r = cyc; sw[0] = 1'b1;
    push(r + 7, 0, 0, 1'b1);
    tick(17);
    rst = 1'b1; sw[0] = 1'b0;
    tick(2); chk("midop_reset_outputs", all_out(), 32'h0);
    rst = 1'b0;
    tick(40); chk("idle_after_midop_reset", all_out(), 32'h0);

    // simultaneous presses on every channel
    s = cyc; sw = '1;
    for (int c = 0; c < NCH; c++) push(s + 7, c, 0, 1'b0);
    tick(10);
    sw = '0;
    for (int c = 0; c < NCH; c++) push(s + 17, c, 1, 1'b1);
    tick(15);
    chk("simul_led_toggled", 32'(led), 32'hF);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
